// File: rtl/spi_input_conditioner_if.sv
// rtl/spi_input_conditioner_if.sv - pad-side raw inputs and conditioned outputs of the SPI input conditioner
interface spi_input_conditioner_if;
  logic cs_raw;
  logic sck_raw;
  logic mosi_raw;
  logic cs_cond;
  logic sck_cond;
  logic mosi_cond;
  logic sck_posedge;
  logic sck_negedge;
  logic cs_negedge;
  logic cs_posedge;

  // pad / stimulus side
  modport master (
    output cs_raw, sck_raw, mosi_raw,
    input  cs_cond, sck_cond, mosi_cond,
    input  sck_posedge, sck_negedge, cs_negedge, cs_posedge
  );

  // conditioner side
  modport slave (
    input  cs_raw, sck_raw, mosi_raw,
    output cs_cond, sck_cond, mosi_cond,
    output sck_posedge, sck_negedge, cs_negedge, cs_posedge
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// rtl/spi_input_conditioner.sv - synchronizer, debouncer and edge detector for the SPI pad signals
module spi_input_conditioner #(
  parameter int counterwidth = 3,
  parameter int waittime     = 3
) (
  input logic                   sclk,
  input logic                   reset,
  spi_input_conditioner_if.slave bus
);
  // channel index: 0 = cs, 1 = sck, 2 = mosi
  localparam int nch = 3;
  // cs idles high (deselected); sck and mosi idle low
  localparam logic [nch-1:0] rst_level = 3'b001;
  localparam logic [counterwidth-1:0] wait_count = counterwidth'(waittime);

  logic [nch-1:0]          raw;
  logic [nch-1:0]          sync0;
  logic [nch-1:0]          sync1;
  logic [nch-1:0]          cond;
  logic [nch-1:0]          accept;
  logic [nch-1:0]          rise;
  logic [nch-1:0]          fall;
  logic [counterwidth-1:0] count [nch];

  assign raw = {bus.mosi_raw, bus.sck_raw, bus.cs_raw};

  // two-flop synchronizer; reset loads the idle level so no spurious change follows release
  always_ff @(posedge sclk) begin
    if (reset) begin
      sync0 <= rst_level;
      sync1 <= rst_level;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // a new level is accepted once it has differed from cond on waittime+1 consecutive edges
  always_comb begin
    accept = '0;
    for (int i = 0; i < nch; i++) begin
      accept[i] = (sync1[i] != cond[i]) && (count[i] == wait_count);
    end
  end

  // stability counters and conditioned levels; any sample at the old level restarts the count
  always_ff @(posedge sclk) begin
    for (int i = 0; i < nch; i++) begin
      if (reset) begin
        count[i] <= '0;
        cond[i]  <= rst_level[i];
      end else if (sync1[i] == cond[i]) begin
        count[i] <= '0;
      end else if (accept[i]) begin
        cond[i]  <= sync1[i];
        count[i] <= '0;
      end else begin
        count[i] <= count[i] + 1'b1;
      end
    end
  end

  // edge pulses registered alongside cond so they line up with the level change
  always_ff @(posedge sclk) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= accept & sync1;
      fall <= accept & ~sync1;
    end
  end

  assign bus.cs_cond     = cond[0];
  assign bus.sck_cond    = cond[1];
  assign bus.mosi_cond   = cond[2];
  assign bus.sck_posedge = rise[1];
  assign bus.sck_negedge = fall[1];
  assign bus.cs_negedge  = fall[0];
  assign bus.cs_posedge  = rise[0];
endmodule

// File: tb/tb_spi_input_conditioner.sv
// tb/tb_spi_input_conditioner.sv - scoreboard bench for spi_input_conditioner
module tb_spi_input_conditioner;
  localparam int W = 3;
  localparam logic [2:0] RST = 3'b001;

  typedef struct {
    int         cyc;
    logic [3:0] pulses; // {cs_posedge, cs_negedge, sck_negedge, sck_posedge}
  } ev_t;

  logic sclk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  spi_input_conditioner_if bus();

  spi_input_conditioner #(.counterwidth(3), .waittime(W)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: history of raw samples per edge; a channel flips when the
  // sample seen by the debouncer (raw from two edges earlier) has been the
  // opposite level for the last W+1 edges
  logic [2:0] hist[$];
  logic [2:0] mcond;
  bit         mvalid = 0;
  ev_t        exp_q[$];

  always @(posedge sclk) begin
    logic [2:0] r;
    logic [2:0] nc;
    logic [3:0] p;
    bit         all;
    ev_t        ev;
    cyc++;
    r = {bus.mosi_raw, bus.sck_raw, bus.cs_raw};
    if (reset) begin
      hist.delete();
      hist.push_back(RST);
      hist.push_back(RST);
      mcond  = RST;
      mvalid = 1;
    end else if (mvalid) begin
      hist.push_back(r);
      if (hist.size() > 40) void'(hist.pop_front());
      nc = mcond;
      for (int i = 0; i < 3; i++) begin
        all = (hist.size() >= W + 3);
        if (all) begin
          for (int j = 0; j <= W; j++) begin
            if (hist[hist.size() - 3 - j][i] == mcond[i]) all = 0;
          end
        end
        if (all) nc[i] = ~mcond[i];
      end
      p = {nc[0] & ~mcond[0], ~nc[0] & mcond[0], ~nc[1] & mcond[1], nc[1] & ~mcond[1]};
      mcond = nc;
      if (p != 4'b0) begin
        ev.cyc = cyc;
        ev.pulses = p;
        exp_q.push_back(ev);
      end
    end
  end

  // monitor: compare levels every cycle, pop the scoreboard whenever a pulse appears
  bit   frame_active = 0;
  logic frame_bit = 0;
  int   cnt_sckp = 0, cnt_sckn = 0, cnt_csn = 0, cnt_csp = 0;

  always @(negedge sclk) begin
    logic [3:0] dp;
    ev_t        e;
    if (mvalid) begin
      dp = {bus.cs_posedge, bus.cs_negedge, bus.sck_negedge, bus.sck_posedge};
      check("cond_levels", {29'b0, bus.mosi_cond, bus.sck_cond, bus.cs_cond}, {29'b0, mcond});
      if (dp != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", {28'b0, dp}, 32'b0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_vec", {28'b0, dp}, {28'b0, e.pulses});
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("pulse_missed", {28'b0, dp}, {28'b0, e.pulses});
      end
      if (dp[0] && frame_active) check("mosi_at_sck_rise", {31'b0, bus.mosi_cond}, {31'b0, frame_bit});
      cnt_sckp += int'(dp[0]);
      cnt_sckn += int'(dp[1]);
      cnt_csn  += int'(dp[2]);
      cnt_csp  += int'(dp[3]);
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sclk);
  endtask

  task automatic check_idle_state(input string name);
    check(name, {25'b0, bus.cs_cond, bus.sck_cond, bus.mosi_cond, bus.sck_posedge,
                 bus.sck_negedge, bus.cs_negedge, bus.cs_posedge}, 32'b1000000);
  endtask

  initial begin
    int s0, s1, s2, s3, pulses;
    logic [7:0] byte_val;

    // reset with non-idle pad levels
    reset = 1'b1;
    bus.cs_raw = 1'b0; bus.sck_raw = 1'b1; bus.mosi_raw = 1'b1;
    @(negedge sclk);
    check_idle_state("reset_state_1");
    @(negedge sclk);
    check_idle_state("reset_state_2");
    reset = 1'b0;
    bus.cs_raw = 1'b1; bus.sck_raw = 1'b0; bus.mosi_raw = 1'b0;
    @(negedge sclk);
    check_idle_state("after_release");
    wait_cycles(8);

    // clean rise: cond and pulse appear after edge E0+5
    bus.sck_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge sclk);
      check("rise_lat_cond", {31'b0, bus.sck_cond}, {31'b0, (k >= 5)});
      check("rise_lat_pulse", {31'b0, bus.sck_posedge}, {31'b0, (k == 5)});
    end
    bus.sck_raw = 1'b0;
    wait_cycles(12);

    // glitch of 3 cycles is rejected, 10 cycles passes once
    bus.sck_raw = 1'b1;
    wait_cycles(3);
    bus.sck_raw = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sclk);
      pulses += int'(bus.sck_posedge);
    end
    check("glitch_cond", {31'b0, bus.sck_cond}, 32'd0);
    check("glitch_pulses", pulses, 0);
    bus.sck_raw = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sclk);
      pulses += int'(bus.sck_posedge);
    end
    check("long_high_pulses", pulses, 1);
    bus.sck_raw = 1'b0;
    wait_cycles(12);

    // counter restart on mosi: 3 high, 1 low, then high
    bus.mosi_raw = 1'b1;
    wait_cycles(3);
    bus.mosi_raw = 1'b0;
    wait_cycles(1);
    bus.mosi_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge sclk);
      check("restart_lat_cond", {31'b0, bus.mosi_cond}, {31'b0, (k >= 5)});
    end
    bus.mosi_raw = 1'b0;
    wait_cycles(12);

    // transaction framing: one byte, 16-cycle sck periods
    s0 = cnt_csn; s1 = cnt_sckp; s2 = cnt_sckn; s3 = cnt_csp;
    byte_val = 8'($urandom_range(0, 255));
    bus.cs_raw = 1'b0;
    wait_cycles(10);
    frame_active = 1;
    for (int b = 7; b >= 0; b--) begin
      bus.sck_raw = 1'b0;
      bus.mosi_raw = byte_val[b];
      frame_bit = byte_val[b];
      wait_cycles(8);
      bus.sck_raw = 1'b1;
      wait_cycles(8);
    end
    bus.sck_raw = 1'b0;
    wait_cycles(10);
    frame_active = 0;
    bus.cs_raw = 1'b1;
    wait_cycles(10);
    check("frame_cs_negedge", cnt_csn - s0, 1);
    check("frame_sck_posedge", cnt_sckp - s1, 8);
    check("frame_sck_negedge", cnt_sckn - s2, 8);
    check("frame_cs_posedge", cnt_csp - s3, 1);

    // reset while an sck count is in progress and cs is selected
    bus.cs_raw = 1'b0;
    wait_cycles(10);
    bus.sck_raw = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    @(negedge sclk);
    check("midrst_cs_cond", {31'b0, bus.cs_cond}, 32'd1);
    check("midrst_cs_posedge", {31'b0, bus.cs_posedge}, 32'd0);
    check("midrst_sck_cond", {31'b0, bus.sck_cond}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge sclk);
      check("midrst_relat_cond", {31'b0, bus.sck_cond}, {31'b0, (k >= 5)});
    end

    // randomized pad activity with occasional resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge sclk);
      if ($urandom_range(0, 4) == 0) bus.cs_raw = ~bus.cs_raw;
      if ($urandom_range(0, 3) == 0) bus.sck_raw = ~bus.sck_raw;
      if ($urandom_range(0, 5) == 0) bus.mosi_raw = ~bus.mosi_raw;
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge sclk);
    reset = 1'b0;
    wait_cycles(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_input_conditioner.md
Name: spi_input_conditioner

Overview:
- Front-end stage of the SPI memory. Takes the three asynchronous pad signals (chip select, serial clock, MOSI) and produces the clean, system-clock-synchronous versions the control FSM and shift register consume.
- Each channel has:
  - a two-flop synchronizer;
  - a stability-counter debouncer;
  - single-cycle rising and falling edge pulses.
- The serial-clock edge pulses are the shift/sample enables for the downstream shift register and FSM.

Parameters:
- counterwidth, 3, width of each per-channel debounce counter.
- waittime, 3, required value of the counter before a new level is accepted. Must satisfy waittime < 2^counterwidth; legal range 1..2^counterwidth-1.

Ports:
- sclk  input  1  system clock; everything updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cs_raw  input  1  asynchronous chip select from pad, active low.
- sck_raw  input  1  asynchronous SPI serial clock from pad.
- mosi_raw  input  1  asynchronous MOSI from pad.
- cs_cond  output  1  debounced chip select.
- sck_cond  output  1  debounced serial clock.
- mosi_cond  output  1  debounced MOSI.
- sck_posedge  output  1  one-cycle pulse on a 0->1 transition of sck_cond.
- sck_negedge  output  1  one-cycle pulse on a 1->0 transition of sck_cond.
- cs_negedge  output  1  one-cycle pulse on a 1->0 transition of cs_cond (transaction start).
- cs_posedge  output  1  one-cycle pulse on a 0->1 transition of cs_cond (transaction end).

Behaviour:
- Clock and reset:
  - One clock, sclk; reset is synchronous and active-high.
  - With reset high at a sclk edge, the following hold after that edge:
    - cs channel: sync0, sync1 and cs_cond = 1 (deselected).
    - sck channel: sync0, sync1 and sck_cond = 0.
    - mosi channel: sync0, sync1 and mosi_cond = 0.
    - All debounce counters = 0.
    - All four edge pulses = 0.
  - Reset mid-transaction discards in-progress counts. No pulse is produced by reset itself, including when cs_cond goes 0->1 because of reset.
- Synchronizer (per channel):
  - sync0 <= raw; sync1 <= sync0.
  - Only sync1 feeds the debouncer.
- Debouncer (per channel, all registered):
  - sync1 == cond: counter <= 0.
  - sync1 != cond and counter == waittime: cond <= sync1, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - A level reaches cond only after sync1 has differed from cond on waittime+1 consecutive edges.
  - Any sample back at the old level clears the counter, so a glitch shorter than waittime+1 synced samples never reaches cond.
  - The counter never wraps, given the parameter constraint.
- Latency:
  - Define edge E0 as the first sclk edge at which sync0 captures a new, stable raw level.
  - cond changes at edge E0 + waittime + 2.
  - With waittime=3: 5 edges after E0, 6 edges including E0.
- Edge pulses:
  - Registered and asserted in the same cycle that the corresponding cond register changes.
  - Exactly one cycle wide; otherwise 0.
  - Rising and falling pulses of one channel are never high together.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous transitions on several raw inputs produce simultaneous pulses when the waittime values match.
  - No cross-channel gating; cs does not mask sck pulses. Gating is the FSM's job.
- Throughput: the minimum raw high or low time that survives is waittime+1 sclk cycles. The SPI master must respect this.

Test Plan:
- Reset: assert reset 2 cycles with cs_raw=0, sck_raw=1, mosi_raw=1 -> cs_cond=1, sck_cond=0, mosi_cond=0, all pulses 0, both during reset and on the first cycle after release.
- Clean rise (waittime=3): sck_raw 0->1 held, E0 = first capture edge -> sck_cond=1 and sck_posedge=1 after edge E0+5; sck_posedge=0 after E0+6; exactly one pulse total.
- Glitch rejection: from sck_cond=0, drive sck_raw high for 3 cycles then low -> sck_cond stays 0, no sck_posedge; then high for 10 cycles -> exactly one sck_posedge.
- Counter restart: mosi_raw high 3 cycles, low 1 cycle, high steady -> mosi_cond rises waittime+2 edges after the final rising sample is captured, not earlier.
- Transaction framing: cs_raw 1->0, 8 sck_raw periods of 16 cycles each, cs_raw 0->1 -> one cs_negedge, 8 sck_posedge, 8 sck_negedge, one cs_posedge, strictly in that order; mosi_cond matches the driven bit at every sck_posedge.
- Reset mid-operation: reset asserted while an sck counter = 2 and cs_cond=0 -> next cycle cs_cond=1, counters 0, no cs_posedge pulse; after release, a held sck_raw=1 needs the full waittime+3 edges again.
